fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the FIFO write-data word width in bits.
REQ-002 SHALL have port w_clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port wrst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port s0_valid  input  1  source 0 (single-word requester) has a word pending.
REQ-005 SHALL have port s0_data  input  DATA_WIDTH  source 0 word.
REQ-006 SHALL have port s0_ready  output  1  one-cycle accept strobe to source 0.
REQ-007 SHALL have port s1_valid  input  1  source 1 (double-word requester) has a result pending.
REQ-008 SHALL have port s1_data  input  2*DATA_WIDTH  source 1 result; low half sent first.
REQ-009 SHALL have port s1_ready  output  1  one-cycle accept strobe to source 1.
REQ-010 SHALL have port full  input  1  FIFO full flag, w_clk domain.
REQ-011 SHALL have port w_inc  output  1  FIFO write strobe.
REQ-012 SHALL have port w_data  output  DATA_WIDTH  FIFO write data.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SEND_LO, SEND_HI, held in a state register.
REQ-015 SHALL, in IDLE with at least one valid, grant one source, load hold register (2*DATA_WIDTH; s0: low half = s0_data, high half = 0), record word count (1 for s0, 2 for s1), and go to SEND_LO.
REQ-016 SHALL assert sX_ready combinationally in the IDLE cycle in which source X is granted, for exactly one cycle per grant.
REQ-017 SHALL arbitrate round-robin: with both valid, grant the source not granted last; with one valid, grant it regardless of history.
REQ-018 SHALL drive w_inc = !full while in SEND_LO or SEND_HI, and 0 in IDLE; w_inc SHALL never be high while full is high.
REQ-019 SHALL drive w_data = hold low half in SEND_LO, hold high half in SEND_HI, and all zeros in IDLE.
REQ-020 SHALL, in SEND_LO with !full: go to SEND_HI if word count is 2, otherwise to IDLE.
REQ-021 SHALL, in SEND_HI with !full, go to IDLE.
REQ-022 SHALL hold state and hold register unchanged while full is high (stall of any length); no word is dropped or duplicated.
REQ-023 SHALL not accept a new grant until IDLE is re-entered; minimum per-grant occupancy is 2 cycles for s0 and 3 cycles for s1 (grant cycle plus one per word).
REQ-024 SHALL keep the two halves of an s1 result contiguous in the FIFO; no s0 word is inserted between them.

Reset
REQ-025 SHALL, on wrst_n low, immediately force state = IDLE, hold register = 0, word count = 0, last-grant = s1 (so s0 wins the first contention).
REQ-026 SHALL, during and after reset, present w_inc = 0, w_data = 0, s0_ready = 0, s1_ready = 0, busy = 0; a transfer in progress is abandoned.

Configuration
REQ-027 SHALL, when macro FIFO_WR_ARB_CNT_EN is defined, add output wr_count (16 bits) counting FIFO words written (w_inc high), reset to 0, saturating at 0xFFFF.
REQ-028 SHALL, when FIFO_WR_ARB_CNT_EN is undefined, omit the wr_count port and counter entirely; all other behaviour identical.

Verification
REQ-029 SHALL cover: s0_valid=1, s0_data=0xA5, full=0 -> s0_ready one cycle; next cycle w_inc=1, w_data=0xA5; then IDLE, busy=0.
REQ-030 SHALL cover: s1_valid=1, s1_data=0x1234, full=0 -> w_data 0x34 then 0x12 on consecutive cycles with w_inc=1.
REQ-031 SHALL cover: both valid continuously after reset -> grant order s0, s1, s0, s1; FIFO sequence s0 word, s1 low, s1 high, s0 word.
REQ-032 SHALL cover: full=1 for 5 cycles during SEND_HI of 0xBEEF -> w_inc=0 for those 5 cycles; w_data stays 0xBE; 0xBE written once after full drops.
REQ-033 SHALL cover: wrst_n pulsed low in SEND_LO -> w_inc=0, busy=0 same cycle; after release, the next contention grants s0.
REQ-034 SHALL cover (FIFO_WR_ARB_CNT_EN defined): three s1 grants -> wr_count=6; with the counter preloaded near 0xFFFF it holds at 0xFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter merging a single-word and a double-word source into one FIFO write port.
// Optional macro FIFO_WR_ARB_CNT_EN adds a saturating 16-bit written-word counter (wr_count).
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      w_clk,
    input  logic                      wrst_n,
    input  logic                      s0_valid,
    input  logic [DATA_WIDTH-1:0]     s0_data,
    output logic                      s0_ready,
    input  logic                      s1_valid,
    input  logic [2*DATA_WIDTH-1:0]   s1_data,
    output logic                      s1_ready,
    input  logic                      full,
    output logic                      w_inc,
    output logic [DATA_WIDTH-1:0]     w_data,
    output logic                      busy
`ifdef FIFO_WR_ARB_CNT_EN
    ,
    output logic [15:0]               wr_count
`endif
);

    localparam int unsigned HOLD_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold;
    logic [1:0]          word_cnt;
    logic                last_s1;
    logic                in_idle;
    logic                gnt0;
    logic                gnt1;

    // Grants are only issued from IDLE; the contended winner alternates via last_s1.
    assign in_idle = (state == IDLE);
    assign gnt0    = wrst_n && in_idle && s0_valid && (!s1_valid || last_s1);
    assign gnt1    = wrst_n && in_idle && s1_valid && (!s0_valid || !last_s1);

    assign s0_ready = gnt0;
    assign s1_ready = gnt1;
    assign busy     = !in_idle;
    assign w_inc    = !in_idle && !full;

    always_comb begin
        w_data = '0;
        case (state)
            SEND_LO: w_data = hold[DATA_WIDTH-1:0];
            SEND_HI: w_data = hold[HOLD_W-1:DATA_WIDTH];
            default: w_data = '0;
        endcase
    end

    // State, hold register and round-robin history; everything freezes while full is high.
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            hold     <= '0;
            word_cnt <= 2'd0;
            last_s1  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0) begin
                        hold     <= {DATA_WIDTH'(0), s0_data};
                        word_cnt <= 2'd1;
                        last_s1  <= 1'b0;
                        state    <= SEND_LO;
                    end else if (gnt1) begin
                        hold     <= s1_data;
                        word_cnt <= 2'd2;
                        last_s1  <= 1'b1;
                        state    <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (!full) begin
                        state <= (word_cnt == 2'd2) ? SEND_HI : IDLE;
                    end
                end
                SEND_HI: begin
                    if (!full) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_CNT_EN
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_count <= 16'd0;
        end else if (w_inc && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule
